// File: rtl/prime_pkg.sv
// prime_pkg: constants shared by the prime search initiator and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   SEED_W      - width of seeds, candidates and results
//   FIRST_PRIME - smallest prime; low seeds snap up to it
//   CAND_STEP   - stride between odd candidates
//   ST_*        - 3-bit state encoding of the search FSM
package prime_pkg;

  localparam int SEED_W      = 8;
  localparam int FIRST_PRIME = 2;
  localparam int CAND_STEP   = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_NEXT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Latency: count visible one cycle after the enabling cycle.
// Backpressure: none; clear has priority over enable.
//
// Ports:
//   clk, rst - clock and asynchronous active-high reset (count -> 0)
//   clr      - synchronous clear to zero
//   en       - increment by one unless already saturated
//   cnt      - current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prime_search.sv
// prime_search: walks candidates upward from a seed, asking an external
//   CheckPrime for each one, and returns the first accepted prime.
// Latency: seed already prime with an N-cycle checker -> done at accept+N+2.
// Backpressure: start is only honoured in IDLE; one query in flight at a time.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start, seed       - search request and its lower bound (sampled in IDLE)
//   busy              - search in progress (ISSUE/WAIT/NEXT)
//   done, fail        - one-cycle completion pulse, fail valid with it
//   prime             - result (0 on fail), held until next accepted start
//   attempts, cycles  - queries issued and cycles spent, both saturating
//   chk_start/chk_num - query pulse and candidate towards the checker
//   chk_finish        - checker completion, with chk_is_prime and
//   chk_assume_prime    the probable-prime verdict
module prime_search
  import prime_pkg::*;
#(
  parameter int TIMEOUT         = 4096,
  parameter int ACCEPT_PROBABLE = 0,
  parameter int CYC_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       seed,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [7:0]       prime,
  output logic [7:0]       attempts,
  output logic [CYC_W-1:0] cycles,
  output logic             chk_start,
  output logic [7:0]       chk_num,
  input  logic             chk_finish,
  input  logic             chk_is_prime,
  input  logic             chk_assume_prime
);

  // One spare bit so the wait counter can never saturate before it
  // reaches TIMEOUT-1, whatever TIMEOUT is.
  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [SEED_W-1:0] cand_q,  cand_d;
  logic [SEED_W-1:0] prime_q, prime_d;
  logic              fail_q,  fail_d;

  logic [SEED_W-1:0] first_cand;
  logic [SEED_W:0]   next_cand;
  logic              start_acc;
  logic              in_issue;
  logic              in_wait;
  logic              in_busy;
  logic              accept;
  logic              tmo_hit;
  logic [TMO_W-1:0]  tmo_cnt;

  assign start_acc = (state_q == ST_IDLE) && start;
  assign in_issue  = (state_q == ST_ISSUE);
  assign in_wait   = (state_q == ST_WAIT);
  assign in_busy   = in_issue || in_wait || (state_q == ST_NEXT);
  assign accept    = chk_is_prime || ((ACCEPT_PROBABLE != 0) && chk_assume_prime);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  // Seeds at or below 2 start at 2 (the only even prime); any other even
  // seed moves to the next odd value. An even seed > 2 is at most 254, so
  // seed+1 always fits.
  always_comb begin
    if (seed <= SEED_W'(FIRST_PRIME)) begin
      first_cand = SEED_W'(FIRST_PRIME);
    end else if (!seed[0]) begin
      first_cand = seed + SEED_W'(1);
    end else begin
      first_cand = seed;
    end
  end

  // Computed one bit wider so stepping past 255 is visible as a carry
  // instead of wrapping back to a small candidate.
  always_comb begin
    if (cand_q == SEED_W'(FIRST_PRIME)) begin
      next_cand = (SEED_W + 1)'(FIRST_PRIME + 1);
    end else begin
      next_cand = {1'b0, cand_q} + (SEED_W + 1)'(CAND_STEP);
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    prime_d = prime_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cand_d  = first_cand;
          prime_d = '0;
          fail_d  = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A verdict arriving in the same cycle as the timeout is honoured.
        if (chk_finish) begin
          if (accept) begin
            prime_d = cand_q;
            state_d = ST_DONE;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (tmo_hit) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_NEXT: begin
        if (next_cand[SEED_W]) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cand_d  = next_cand[SEED_W-1:0];
          state_d = ST_ISSUE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      prime_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      prime_q <= prime_d;
      fail_q  <= fail_d;
    end
  end

  // Queries issued in this search.
  sat_counter #(.W(8)) u_attempts (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (in_issue),
    .cnt (attempts)
  );

  // Cycles spent working: ISSUE, WAIT and NEXT all count.
  sat_counter #(.W(CYC_W)) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (in_busy),
    .cnt (cycles)
  );

  // Per-query wait budget, restarted by every ISSUE.
  sat_counter #(.W(TMO_W)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (in_issue),
    .en  (in_wait),
    .cnt (tmo_cnt)
  );

  assign busy      = in_busy;
  assign done      = (state_q == ST_DONE);
  assign fail      = fail_q;
  assign prime     = prime_q;
  assign chk_start = in_issue;
  assign chk_num   = in_issue ? cand_q : '0;

endmodule

// File: tb/tb_prime_search.sv
module tb_prime_search;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  seed;
  logic        busy, done, fail;
  logic [7:0]  prime, attempts;
  logic [15:0] cycles;
  logic        chk_start;
  logic [7:0]  chk_num;
  logic        chk_finish, chk_is_prime, chk_assume_prime;

  always #5 clk = ~clk;

  prime_search #(.TIMEOUT(TMO), .ACCEPT_PROBABLE(0), .CYC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy), .done(done), .fail(fail), .prime(prime),
    .attempts(attempts), .cycles(cycles),
    .chk_start(chk_start), .chk_num(chk_num),
    .chk_finish(chk_finish), .chk_is_prime(chk_is_prime),
    .chk_assume_prime(chk_assume_prime)
  );

  int errors = 0;
  int checks = 0;

  // Checker stub configuration: latency in cycles and verdict mode
  // (0 = true primality, 1 = true primality but rejects 2, 2 = never answers).
  int resp_n    = 1;
  int resp_mode = 0;
  logic [7:0] q_seen[$];
  bit num_bad;
  bit busy_bad;

  // Reference model results.
  int exp_q[$];
  int exp_prime;
  int exp_fail;
  int exp_cycles;

  int lat;
  bit ok;

  function automatic bit is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit verdict(input int v, input int mode);
    if (mode == 2) return 1'b0;
    if (mode == 1 && v == 2) return 1'b0;
    return is_prime(v);
  endfunction

  // Search semantics: start candidate, odd stepping, stop on accept or
  // past 255; cycle count = per query (1 issue + n wait) plus one step
  // cycle between queries (and one more when stepping overflows).
  task automatic model(input int s, input int mode, input int n);
    int c;
    bit fin;
    exp_q.delete();
    exp_prime = 0;
    exp_fail  = 0;
    fin = 1'b0;
    c = (s <= 2) ? 2 : ((s % 2 == 0) ? s + 1 : s);
    while (!fin) begin
      exp_q.push_back(c);
      if (mode == 2) begin
        exp_fail = 1; exp_cycles = 1 + TMO; fin = 1'b1;
      end else if (verdict(c, mode)) begin
        exp_prime = c; exp_cycles = exp_q.size() * (n + 1) + exp_q.size() - 1; fin = 1'b1;
      end else begin
        c = (c == 2) ? 3 : c + 2;
        if (c > 255) begin
          exp_fail = 1; exp_cycles = exp_q.size() * (n + 2); fin = 1'b1;
        end
      end
    end
  endtask

  // Checker stub: records every query, answers resp_n cycles later.
  initial begin
    int cnt;
    cnt = 0;
    chk_finish = 1'b0; chk_is_prime = 1'b0; chk_assume_prime = 1'b0;
    forever begin
      @(negedge clk);
      chk_finish = 1'b0; chk_is_prime = 1'b0; chk_assume_prime = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (chk_start) begin
        q_seen.push_back(chk_num);
        cnt = (resp_mode == 2) ? 0 : resp_n;
      end else begin
        if (chk_num !== 8'd0) num_bad = 1'b1;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            chk_finish = 1'b1;
            chk_is_prime = verdict(int'(q_seen[$]), resp_mode);
            chk_assume_prime = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  end

  // Pulse start, then watch for done. lat = cycles from the start cycle to
  // the done cycle. Optionally pokes a stray start while busy.
  task automatic run_search(input logic [7:0] s, input int n, input int mode,
                            input int poke_at, output int l, output bit got);
    resp_n = n; resp_mode = mode;
    q_seen.delete(); num_bad = 1'b0; busy_bad = 1'b0;
    @(negedge clk);
    seed = s; start = 1'b1; l = 0; got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      start = 1'b0; l++;
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_bad = 1'b1;
        if (l == poke_at) begin seed = 8'd3; start = 1'b1; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seed = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if ({busy, done, fail, chk_start} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, fail, chk_start}); end
    checks++; if (prime !== 8'd0) begin errors++; $display("FAIL reset_prime got=%0d exp=0", prime); end
    checks++; if (attempts !== 8'd0 || cycles !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", attempts, cycles); end
    checks++; if (chk_num !== 8'd0) begin errors++; $display("FAIL reset_chk_num got=%0d exp=0", chk_num); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_seed7();
    run_search(8'd7, 3, 0, -1, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seed7_done got=no_done exp=done"); end
    checks++; if (q_seen.size() != 1 || q_seen[0] !== 8'd7) begin errors++; $display("FAIL seed7_queries got=%0d_queries first=%0d exp=1_query 7", q_seen.size(), q_seen[0]); end
    checks++; if (prime !== 8'd7 || fail !== 1'b0) begin errors++; $display("FAIL seed7_result got=%0d/%b exp=7/0", prime, fail); end
    checks++; if (attempts !== 8'd1) begin errors++; $display("FAIL seed7_attempts got=%0d exp=1", attempts); end
    checks++; if (lat != 5 || cycles !== 16'd4) begin errors++; $display("FAIL seed7_latency got=%0d/%0d exp=5/4", lat, cycles); end
    checks++; if (busy !== 1'b0 || busy_bad) begin errors++; $display("FAIL seed7_busy got=%b/%b exp=0/0", busy, busy_bad); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || prime !== 8'd7 || attempts !== 8'd1) begin errors++; $display("FAIL seed7_hold got=%b/%0d/%0d exp=0/7/1", done, prime, attempts); end
  endtask

  task automatic test_seed8();
    run_search(8'd8, 2, 0, -1, lat, ok);
    checks++; if (!ok || q_seen.size() != 2 || q_seen[0] !== 8'd9 || q_seen[1] !== 8'd11) begin errors++; $display("FAIL seed8_queries got=%0d_queries done=%b exp=9,11", q_seen.size(), ok); end
    checks++; if (prime !== 8'd11 || attempts !== 8'd2 || fail !== 1'b0) begin errors++; $display("FAIL seed8_result got=%0d/%0d/%b exp=11/2/0", prime, attempts, fail); end
    checks++; if (cycles !== 16'd7 || lat != 8) begin errors++; $display("FAIL seed8_cycles got=%0d/%0d exp=7/8", cycles, lat); end
  endtask

  task automatic test_small_seeds();
    run_search(8'd0, 1, 0, -1, lat, ok);
    checks++; if (!ok || q_seen.size() != 1 || q_seen[0] !== 8'd2 || prime !== 8'd2) begin errors++; $display("FAIL seed0_prime2 got=%0d_queries prime=%0d exp=1_query prime=2", q_seen.size(), prime); end
    run_search(8'd0, 1, 1, -1, lat, ok);
    checks++; if (!ok || q_seen.size() != 2 || q_seen[0] !== 8'd2 || q_seen[1] !== 8'd3) begin errors++; $display("FAIL seed0_reject2 got=%0d_queries exp=2,3", q_seen.size()); end
    checks++; if (prime !== 8'd3 || attempts !== 8'd2) begin errors++; $display("FAIL seed0_reject2_result got=%0d/%0d exp=3/2", prime, attempts); end
    run_search(8'd1, 2, 0, -1, lat, ok);
    checks++; if (!ok || q_seen.size() != 1 || q_seen[0] !== 8'd2 || prime !== 8'd2) begin errors++; $display("FAIL seed1_prime2 got=%0d_queries prime=%0d exp=1_query prime=2", q_seen.size(), prime); end
  endtask

  task automatic test_overflow();
    run_search(8'd252, 1, 0, -1, lat, ok);
    checks++; if (!ok || q_seen.size() != 2 || q_seen[0] !== 8'd253 || q_seen[1] !== 8'd255) begin errors++; $display("FAIL ovf_queries got=%0d_queries done=%b exp=253,255", q_seen.size(), ok); end
    checks++; if (fail !== 1'b1 || prime !== 8'd0 || attempts !== 8'd2) begin errors++; $display("FAIL ovf_result got=%b/%0d/%0d exp=1/0/2", fail, prime, attempts); end
    checks++; if (cycles !== 16'd6 || lat != 7) begin errors++; $display("FAIL ovf_cycles got=%0d/%0d exp=6/7", cycles, lat); end
  endtask

  task automatic test_timeout();
    // Stray start injected while waiting must not disturb the search.
    run_search(8'd50, 1, 2, 5, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_done got=no_done exp=done"); end
    checks++; if (lat != 2 + TMO || cycles !== 16'(1 + TMO)) begin errors++; $display("FAIL tmo_timing got=%0d/%0d exp=%0d/%0d", lat, cycles, 2 + TMO, 1 + TMO); end
    checks++; if (fail !== 1'b1 || prime !== 8'd0 || attempts !== 8'd1) begin errors++; $display("FAIL tmo_result got=%b/%0d/%0d exp=1/0/1", fail, prime, attempts); end
    checks++; if (q_seen.size() != 1 || q_seen[0] !== 8'd51 || busy_bad) begin errors++; $display("FAIL tmo_queries got=%0d_queries busy_bad=%b exp=1_query(51) 0", q_seen.size(), busy_bad); end
  endtask

  task automatic test_reset_mid_wait();
    bit reached;
    resp_n = 10; resp_mode = 0; q_seen.delete(); reached = 1'b0;
    @(negedge clk);
    seed = 8'd90; start = 1'b1;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (attempts == 8'd2) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstwait_reach got=attempts_%0d exp=attempts_2", attempts); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, done, fail, chk_start} !== 4'b0 || prime !== 8'd0 || chk_num !== 8'd0) begin errors++; $display("FAIL rstwait_outputs got=%b/%0d/%0d exp=0000/0/0", {busy, done, fail, chk_start}, prime, chk_num); end
    checks++; if (attempts !== 8'd0 || cycles !== 16'd0) begin errors++; $display("FAIL rstwait_counts got=%0d/%0d exp=0/0", attempts, cycles); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_search(8'd90, 3, 0, -1, lat, ok);
    checks++; if (!ok || prime !== 8'd97 || attempts !== 8'd4 || fail !== 1'b0) begin errors++; $display("FAIL rstwait_rerun got=%0d/%0d/%b exp=97/4/0", prime, attempts, fail); end
    checks++; if (cycles !== 16'd19 || q_seen.size() != 4 || q_seen[0] !== 8'd91) begin errors++; $display("FAIL rstwait_rerun_cycles got=%0d/%0d_queries exp=19/4", cycles, q_seen.size()); end
  endtask

  task automatic test_random();
    int s, n, m;
    for (int it = 0; it < 30; it++) begin
      s = $urandom_range(0, 255);
      n = $urandom_range(1, 4);
      m = $urandom_range(0, 1);
      model(s, m, n);
      run_search(8'(s), n, m, -1, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_done seed=%0d got=no_done exp=done", s); end
      checks++; if (prime !== 8'(exp_prime) || fail !== 1'(exp_fail)) begin errors++; $display("FAIL rnd_result seed=%0d got=%0d/%b exp=%0d/%0d", s, prime, fail, exp_prime, exp_fail); end
      checks++; if (attempts !== 8'(exp_q.size()) || cycles !== 16'(exp_cycles) || lat != exp_cycles + 1) begin errors++; $display("FAIL rnd_counts seed=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", s, attempts, cycles, lat, exp_q.size(), exp_cycles, exp_cycles + 1); end
      checks++; if (q_seen.size() != exp_q.size()) begin errors++; $display("FAIL rnd_nqueries seed=%0d got=%0d exp=%0d", s, q_seen.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < q_seen.size(); k++) begin
        checks++; if (q_seen[k] !== 8'(exp_q[k])) begin errors++; $display("FAIL rnd_query seed=%0d idx=%0d got=%0d exp=%0d", s, k, q_seen[k], exp_q[k]); end
      end
      checks++; if (num_bad || busy_bad) begin errors++; $display("FAIL rnd_idle_outputs seed=%0d got=num_bad=%b busy_bad=%b exp=0/0", s, num_bad, busy_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_seed7();
    test_seed8();
    test_small_seeds();
    test_overflow();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
